// File: rtl/minn_peak_detector_if.sv
`default_nettype none
// =============================================================================
// minn_peak_detector_if : tap input / detection output bundle of the Minn peak detector
// Revision 1.0
// =============================================================================
interface minn_peak_detector_if #(
  parameter int CORR_WIDTH   = 35,
  parameter int ENERGY_WIDTH = 35,
  parameter int THRESH_FRAC  = 16,
  parameter int INDEX_WIDTH  = 32
);
  logic                           taps_valid;
  logic signed [CORR_WIDTH-1:0]   corr_recent;
  logic signed [CORR_WIDTH-1:0]   corr_previous;
  logic signed [ENERGY_WIDTH-1:0] energy_recent;
  logic signed [ENERGY_WIDTH-1:0] energy_previous;
  logic [THRESH_FRAC-1:0]         threshold;
  logic [ENERGY_WIDTH:0]          min_energy;
  logic                           detect_valid;
  logic [INDEX_WIDTH-1:0]         peak_index;
  logic [CORR_WIDTH:0]            peak_corr;
  logic [ENERGY_WIDTH:0]          peak_energy;
  logic                           busy;

  modport master (
    output taps_valid, corr_recent, corr_previous, energy_recent, energy_previous,
    output threshold, min_energy,
    input  detect_valid, peak_index, peak_corr, peak_energy, busy
  );

  modport slave (
    input  taps_valid, corr_recent, corr_previous, energy_recent, energy_previous,
    input  threshold, min_energy,
    output detect_valid, peak_index, peak_corr, peak_energy, busy
  );
endinterface
`default_nettype wire

// File: rtl/minn_peak_detector.sv
`default_nettype none
// =============================================================================
// minn_peak_detector : C/E threshold trigger, windowed peak search, holdoff
// Revision 1.0
// =============================================================================
module minn_peak_detector #(
  parameter int CORR_WIDTH   = 35,
  parameter int ENERGY_WIDTH = 35,
  parameter int THRESH_FRAC  = 16,
  parameter int SEARCH_LEN   = 64,
  parameter int HOLDOFF_LEN  = 1024,
  parameter int INDEX_WIDTH  = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  minn_peak_detector_if.slave bus_io
);
  localparam int CW1 = CORR_WIDTH + 1;
  localparam int EW1 = ENERGY_WIDTH + 1;
  localparam int KW  = ((CW1 > EW1) ? CW1 : EW1) + THRESH_FRAC;
  localparam int PW  = CW1 + EW1;
  localparam int WW  = $clog2(SEARCH_LEN + 1);
  localparam int HW  = $clog2(HOLDOFF_LEN + 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_LEN);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // stage 1: metric terms
  logic signed [CW1-1:0]  c_sum;
  logic [CW1-1:0]         c_clip;
  logic [EW1-1:0]         e_sum;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   v1_q;
  logic [CW1-1:0]         c1_q;
  logic [EW1-1:0]         e1_q;
  logic [INDEX_WIDTH-1:0] idx1_q;

  assign c_sum  = {bus_io.corr_recent[CORR_WIDTH-1], bus_io.corr_recent}
                + {bus_io.corr_previous[CORR_WIDTH-1], bus_io.corr_previous};
  assign c_clip = c_sum[CW1-1] ? '0 : c_sum;
  assign e_sum  = {1'b0, bus_io.energy_recent} + {1'b0, bus_io.energy_previous};

  // stage 2: threshold decision
  logic [KW-1:0]          c_scaled;
  logic [KW-1:0]          e_scaled;
  logic                   above;
  logic                   v2_q;
  logic                   above2_q;
  logic [CW1-1:0]         c2_q;
  logic [EW1-1:0]         e2_q;
  logic [INDEX_WIDTH-1:0] idx2_q;

  assign c_scaled = KW'(c1_q) << THRESH_FRAC;
  assign e_scaled = KW'(bus_io.threshold) * KW'(e1_q);
  assign above    = (c_scaled >= e_scaled) && (e1_q >= bus_io.min_energy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      v1_q     <= 1'b0;
      c1_q     <= '0;
      e1_q     <= '0;
      idx1_q   <= '0;
      v2_q     <= 1'b0;
      above2_q <= 1'b0;
      c2_q     <= '0;
      e2_q     <= '0;
      idx2_q   <= '0;
    end else begin
      v1_q <= bus_io.taps_valid;
      v2_q <= v1_q;
      if (bus_io.taps_valid) begin
        idx_q  <= idx_q + 1'b1;
        c1_q   <= c_clip;
        e1_q   <= e_sum;
        idx1_q <= idx_q;
      end
      if (v1_q) begin
        above2_q <= above;
        c2_q     <= c1_q;
        e2_q     <= e1_q;
        idx2_q   <= idx1_q;
      end
    end
  end

  // stage 3: search FSM
  state_t                 state_q, state_d;
  logic [WW-1:0]          win_q, win_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [CW1-1:0]         c_best_q, c_best_d;
  logic [EW1-1:0]         e_best_q, e_best_d;
  logic [INDEX_WIDTH-1:0] idx_best_q, idx_best_d;
  logic                   det_q, det_d;
  logic [INDEX_WIDTH-1:0] pk_idx_q, pk_idx_d;
  logic [CW1-1:0]         pk_c_q, pk_c_d;
  logic [EW1-1:0]         pk_e_q, pk_e_d;
  logic                   busy_q;
  logic [PW-1:0]          prod_new;
  logic [PW-1:0]          prod_best;
  logic                   better;
  logic                   load_best;
  logic                   finish;

  // Compared against the live best registers so back-to-back samples see the latest best.
  assign prod_new  = PW'(c2_q) * PW'(e_best_q);
  assign prod_best = PW'(c_best_q) * PW'(e2_q);
  assign better    = prod_new > prod_best;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    hold_d     = hold_q;
    c_best_d   = c_best_q;
    e_best_d   = e_best_q;
    idx_best_d = idx_best_q;
    det_d      = 1'b0;
    pk_idx_d   = pk_idx_q;
    pk_c_d     = pk_c_q;
    pk_e_d     = pk_e_q;
    load_best  = 1'b0;
    finish     = 1'b0;
    if (v2_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (above2_q) begin
            load_best = 1'b1;
            win_d     = WW'(1);
            state_d   = ST_SEARCH;
            finish    = (WW'(1) == WIN_LAST);
          end
        end
        ST_SEARCH: begin
          win_d     = win_q + 1'b1;
          load_best = better;
          finish    = (win_d == WIN_LAST);
        end
        ST_HOLDOFF: begin
          hold_d = hold_q + 1'b1;
          if (hold_d == HOLD_LAST) begin
            hold_d  = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (load_best) begin
      c_best_d   = c2_q;
      e_best_d   = e2_q;
      idx_best_d = idx2_q;
    end
    if (finish) begin
      det_d    = 1'b1;
      pk_idx_d = idx_best_d;
      pk_c_d   = c_best_d;
      pk_e_d   = e_best_d;
      win_d    = '0;
      hold_d   = '0;
      state_d  = ST_HOLDOFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      win_q      <= '0;
      hold_q     <= '0;
      c_best_q   <= '0;
      e_best_q   <= '0;
      idx_best_q <= '0;
      det_q      <= 1'b0;
      pk_idx_q   <= '0;
      pk_c_q     <= '0;
      pk_e_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      hold_q     <= hold_d;
      c_best_q   <= c_best_d;
      e_best_q   <= e_best_d;
      idx_best_q <= idx_best_d;
      det_q      <= det_d;
      pk_idx_q   <= pk_idx_d;
      pk_c_q     <= pk_c_d;
      pk_e_q     <= pk_e_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign bus_io.detect_valid = det_q;
  assign bus_io.peak_index   = pk_idx_q;
  assign bus_io.peak_corr    = pk_c_q;
  assign bus_io.peak_energy  = pk_e_q;
  assign bus_io.busy         = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_minn_peak_detector.sv
`default_nettype none
// =============================================================================
// tb_minn_peak_detector : directed + random stimulus against a sample-list peak model
// Revision 1.0
// =============================================================================
module tb_minn_peak_detector;
  localparam int CW = 35;
  localparam int EW = 35;
  localparam int TF = 16;
  localparam int IW = 32;
  localparam int SL = 4;
  localparam int HL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  longint thr = 32768;
  longint min_e = 16;

  // driven samples since the last reset, and observed detections
  longint s_c[$], s_e[$], s_cyc[$];
  longint d_idx[$], d_corr[$], d_en[$], d_cyc[$];
  bit     busy_log[int];
  int     base;
  int     scen_start;

  minn_peak_detector_if #(.CORR_WIDTH(CW), .ENERGY_WIDTH(EW), .THRESH_FRAC(TF),
                          .INDEX_WIDTH(IW)) bus ();

  minn_peak_detector #(
    .CORR_WIDTH(CW), .ENERGY_WIDTH(EW), .THRESH_FRAC(TF),
    .SEARCH_LEN(SL), .HOLDOFF_LEN(HL), .INDEX_WIDTH(IW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_log[cyc] = bus.busy;
    if (bus.detect_valid === 1'b1) begin
      d_idx.push_back(longint'(bus.peak_index));
      d_corr.push_back(longint'(bus.peak_corr));
      d_en.push_back(longint'(bus.peak_energy));
      d_cyc.push_back(longint'(cyc));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clipc(input longint c);
    return (c < 0) ? 0 : c;
  endfunction

  function automatic bit model_above(input longint c, input longint e);
    return (clipc(c) * 65536 >= thr * e) && (e >= min_e);
  endfunction

  function automatic bit busy_at(input int t);
    return busy_log.exists(t) ? busy_log[t] : 1'b0;
  endfunction

  task automatic drive(input longint c, input longint e, input bit v);
    @(negedge clk);
    bus.taps_valid      = v;
    bus.corr_recent     = CW'(c / 2);
    bus.corr_previous   = CW'(c - c / 2);
    bus.energy_recent   = EW'(e / 2);
    bus.energy_previous = EW'(e - e / 2);
    if (v) begin
      s_c.push_back(c);
      s_e.push_back(e);
      s_cyc.push_back(longint'(cyc));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    bus.taps_valid = 1'b0;
    bus.threshold  = TF'(thr);
    bus.min_energy = (EW+1)'(min_e);
    repeat (3) @(negedge clk);
    check({tag, "_rst_det"},  bus.detect_valid, 0);
    check({tag, "_rst_busy"}, bus.busy, 0);
    check({tag, "_rst_corr"}, bus.peak_corr, 0);
    rst_n = 1'b1;
    s_c.delete(); s_e.delete(); s_cyc.delete();
    base = d_idx.size();
    scen_start = cyc;
  endtask

  task automatic flush();
    repeat (6) drive(0, 0, 1'b0);
  endtask

  // Walks the sample list: trigger, pick the best ratio in the window, skip holdoff.
  task automatic check_scenario(input string tag);
    longint ei[$], ec[$], ee[$], ey[$];
    int i, b, n, nd;
    n = s_c.size();
    i = 0;
    while (i < n) begin
      if (model_above(s_c[i], s_e[i])) begin
        if (i + SL > n) break;
        b = i;
        for (int j = i + 1; j < i + SL; j++)
          if (clipc(s_c[j]) * s_e[b] > clipc(s_c[b]) * s_e[j]) b = j;
        ei.push_back(longint'(b));
        ec.push_back(clipc(s_c[b]));
        ee.push_back(s_e[b]);
        ey.push_back(s_cyc[i + SL - 1] + 3);
        i = i + SL + HL;
      end else begin
        i++;
      end
    end
    nd = d_idx.size() - base;
    check({tag, "_count"}, nd, ei.size());
    for (int k = 0; k < ei.size() && k < nd; k++) begin
      check($sformatf("%s_idx%0d", tag, k),  d_idx[base+k],  ei[k]);
      check($sformatf("%s_corr%0d", tag, k), d_corr[base+k], ec[k]);
      check($sformatf("%s_en%0d", tag, k),   d_en[base+k],   ee[k]);
      check($sformatf("%s_cyc%0d", tag, k),  d_cyc[base+k],  ey[k]);
    end
  endtask

  function automatic longint p1_c(input int i);
    case (i)
      5: return 60;
      6: return 80;
      7: return 70;
      8: return 50;
      default: return 0;
    endcase
  endfunction

  initial begin
    int busy_hits;
    bus.taps_valid = 1'b0;
    bus.corr_recent = '0; bus.corr_previous = '0;
    bus.energy_recent = '0; bus.energy_previous = '0;
    bus.threshold = TF'(thr);
    bus.min_energy = (EW+1)'(min_e);

    // low ratio: never triggers
    do_reset("s1");
    for (int i = 0; i < 50; i++) drive(10, 100, 1'b1);
    flush();
    check_scenario("s1");
    busy_hits = 0;
    for (int t = scen_start; t <= cyc; t++) busy_hits += busy_at(t);
    check("s1_busy_never", busy_hits, 0);

    // trigger and peak
    do_reset("s2");
    for (int i = 0; i < 12; i++) drive(p1_c(i), 100, 1'b1);
    flush();
    check_scenario("s2");
    check("s2_peak_const", (d_idx.size() > base) ? d_idx[base] : -1, 6);
    check("s2_pcorr_const", (d_corr.size() > base) ? d_corr[base] : -1, 80);
    check("s2_busy_pre", busy_at(int'(s_cyc[5]) + 2), 0);
    check("s2_busy_on", busy_at(int'(s_cyc[5]) + 3), 1);

    // tie, holdoff, retrigger
    do_reset("s3");
    for (int i = 0; i < 24; i++)
      drive((i == 5) ? 60 : (i == 6 || i == 7) ? 80 : (i >= 9 && i <= 17) ? 90 : 0, 100, 1'b1);
    flush();
    check_scenario("s3");
    check("s3_first_const", (d_idx.size() > base) ? d_idx[base] : -1, 6);
    check("s3_second_const", (d_idx.size() > base + 1) ? d_idx[base+1] : -1, 17);

    // energy gate and negative C
    do_reset("s4");
    for (int i = 0; i < 10; i++) drive(10, 14, 1'b1);
    for (int i = 0; i < 10; i++) drive(-90, 100, 1'b1);
    flush();
    check_scenario("s4");

    // zero threshold: clipped negative C still triggers
    thr = 0;
    do_reset("s4z");
    for (int i = 0; i < 6; i++) drive(-90, 100, 1'b1);
    flush();
    check_scenario("s4z");
    check("s4z_corr_clip", (d_corr.size() > base) ? d_corr[base] : -1, 0);
    thr = 32768;

    // valid gaps
    do_reset("s5");
    for (int i = 0; i < 12; i++) begin
      drive(p1_c(i), 100, 1'b1);
      drive(0, 0, 1'b0);
    end
    flush();
    check_scenario("s5");
    check("s5_peak_const", (d_idx.size() > base) ? d_idx[base] : -1, 6);

    // async reset in the middle of a second search
    do_reset("s6");
    for (int i = 0; i < 17; i++) drive(p1_c(i), 100, 1'b1);
    drive(60, 100, 1'b1);
    drive(80, 100, 1'b1);
    drive(0, 0, 1'b0);
    @(posedge clk);
    #2;
    check("s6_busy_search", bus.busy, 1);
    check("s6_peak_held", bus.peak_index, 6);
    rst_n = 1'b0;
    #1;
    check("s6_async_det", bus.detect_valid, 0);
    check("s6_async_busy", bus.busy, 0);
    check("s6_async_idx", bus.peak_index, 0);
    check("s6_async_corr", bus.peak_corr, 0);
    check("s6_async_en", bus.peak_energy, 0);
    check_scenario("s6");

    // index restarts at 0 after reset
    do_reset("s7");
    for (int i = 0; i < 12; i++) drive(p1_c(i), 100, 1'b1);
    flush();
    check_scenario("s7");
    check("s7_peak_const", (d_idx.size() > base) ? d_idx[base] : -1, 6);

    // random taps and gaps
    do_reset("s8");
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(3) == 0) drive(0, 0, 1'b0);
      drive(longint'($urandom_range(180)) - 60, longint'($urandom_range(250, 10)), 1'b1);
    end
    flush();
    check_scenario("s8");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
